// File: rtl/pong_match_pkg.sv
// pong_match_pkg: shared match states and index/slice helpers for the pong match controller.
package pong_match_pkg;
    typedef enum logic [2:0] {IDLE, SERVE, RALLY, PAUSE, GAME_OVER} match_state_t;

    function automatic int pidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int score_lsb(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/pong_score_lane.sv
// pong_score_lane: one saturating player score with clear, increment and win-threshold compare.
module pong_score_lane #(
    parameter int SCORE_W = 8,
    parameter int WIN_SCORE = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] next_score,
    output logic               hit
);
    // next_score and hit describe the score as it would be after this cycle's increment
    assign next_score = &score ? score : score + SCORE_W'(1);
    assign hit = next_score >= SCORE_W'(WIN_SCORE);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            score <= '0;
        else if (clr)
            score <= '0;
        else if (inc)
            score <= next_score;
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: N-player serve/rally/pause/game-over match controller with saturating scores.
// Optional PONG_WIN_BY_TWO_EN: a win also needs a two-point lead over every other player.
module pong_match_ctrl
    import pong_match_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W = 8,
    parameter int WIN_SCORE = 11,
    parameter int PAUSE_CYCLES = 4,
    localparam int PIDX_W = pidx_w(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_PLAYERS-1:0]         score_evt,
    output logic                           serve_valid,
    input  logic                           serve_ready,
    output logic [PIDX_W-1:0]              serve_player,
    output logic                           rally_active,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_out,
    output logic                           game_over,
    output logic [PIDX_W-1:0]              winner,
    output logic                           evt_error
);
    localparam int CNT_W = pidx_w(PAUSE_CYCLES + 1);

    match_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PIDX_W-1:0] serve_player_n, winner_n, p;
    logic game_over_n, evt_error_n, clr, one_hot, win;
    logic [NUM_PLAYERS-1:0] inc, hit;
    logic [SCORE_W-1:0] nxt [NUM_PLAYERS];

    assign one_hot = score_evt != '0 && (score_evt & (score_evt - NUM_PLAYERS'(1))) == '0;
    assign clr = (state == IDLE || state == GAME_OVER) && start;
    assign inc = (state == RALLY && one_hot) ? score_evt : '0;

    genvar i;
    generate
        for (i = 0; i < NUM_PLAYERS; i++) begin : g_lane
            pong_score_lane #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_lane (
                .clk(clk),
                .rst(rst),
                .clr(clr),
                .inc(inc[i]),
                .score(score_out[score_lsb(i, SCORE_W) +: SCORE_W]),
                .next_score(nxt[i]),
                .hit(hit[i])
            );
        end
    endgenerate

    always_comb begin
        p = '0;
        for (int q = 0; q < NUM_PLAYERS; q++)
            if (score_evt[q]) p = PIDX_W'(q);
    end

`ifdef PONG_WIN_BY_TWO_EN
    // widened by one bit so that "other + 2" cannot wrap near saturation
    always_comb begin
        win = hit[p];
        for (int q = 0; q < NUM_PLAYERS; q++)
            if (q != int'(p) && (SCORE_W+1)'(nxt[p]) <
                (SCORE_W+1)'(score_out[score_lsb(q, SCORE_W) +: SCORE_W]) + (SCORE_W+1)'(2))
                win = 1'b0;
    end
`else
    assign win = hit[p];
`endif

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        serve_player_n = serve_player;
        winner_n = winner;
        game_over_n = game_over;
        evt_error_n = evt_error;
        case (state)
            IDLE, GAME_OVER:
                if (start) begin
                    state_n = SERVE;
                    serve_player_n = '0;
                    winner_n = '0;
                    game_over_n = 1'b0;
                    evt_error_n = 1'b0;
                end
            SERVE:
                if (serve_ready) state_n = RALLY;
            RALLY:
                if (one_hot) begin
                    serve_player_n = p;
                    if (win) begin
                        state_n = GAME_OVER;
                        game_over_n = 1'b1;
                        winner_n = p;
                    end else begin
                        state_n = PAUSE;
                        cnt_n = CNT_W'(PAUSE_CYCLES);
                    end
                end else if (score_evt != '0)
                    evt_error_n = 1'b1;
            PAUSE:
                if (cnt <= CNT_W'(1)) begin
                    state_n = SERVE;
                    cnt_n = '0;
                end else
                    cnt_n = cnt - CNT_W'(1);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            serve_valid <= 1'b0;
            rally_active <= 1'b0;
            serve_player <= '0;
            winner <= '0;
            game_over <= 1'b0;
            evt_error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            serve_valid <= state_n == SERVE;
            rally_active <= state_n == RALLY;
            serve_player <= serve_player_n;
            winner <= winner_n;
            game_over <= game_over_n;
            evt_error <= evt_error_n;
        end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed checks of a 2-player default match and a 4-player, zero-pause match.
module tb_pong_match_ctrl;
    logic clk = 1'b0;
    logic rst, start, serve_ready, serve_valid, rally_active, game_over, evt_error;
    logic [1:0] score_evt;
    logic [0:0] serve_player, winner;
    logic [15:0] score_out;
    logic start4, ready4, sv4, ra4, go4, ee4;
    logic [3:0] evt4;
    logic [1:0] sp4, w4;
    logic [7:0] so4;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_match_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .score_evt(score_evt),
        .serve_valid(serve_valid), .serve_ready(serve_ready), .serve_player(serve_player),
        .rally_active(rally_active), .score_out(score_out), .game_over(game_over),
        .winner(winner), .evt_error(evt_error)
    );

    pong_match_ctrl #(.NUM_PLAYERS(4), .SCORE_W(2), .WIN_SCORE(3), .PAUSE_CYCLES(0)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .score_evt(evt4),
        .serve_valid(sv4), .serve_ready(ready4), .serve_player(sp4),
        .rally_active(ra4), .score_out(so4), .game_over(go4),
        .winner(w4), .evt_error(ee4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rally;
        int c = 0;
        while (rally_active !== 1'b1 && c < 40) begin
            tick;
            c++;
        end
        chk("wait_rally", 32'(rally_active), 1);
    endtask

    task automatic wait_serve;
        int c = 0;
        while (serve_valid !== 1'b1 && c < 40) begin
            tick;
            c++;
        end
        chk("wait_serve", 32'(serve_valid), 1);
    endtask

    task automatic point(input logic [1:0] evt);
        score_evt = evt;
        tick;
        score_evt = 2'b00;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; score_evt = 2'b00; serve_ready = 1'b0;
        start4 = 1'b0; evt4 = 4'b0; ready4 = 1'b1;
        tick;
        tick;
        chk("rst_serve_valid", 32'(serve_valid), 0);
        chk("rst_rally", 32'(rally_active), 0);
        chk("rst_score", 32'(score_out), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_evt_error", 32'(evt_error), 0);
        chk("rst_score4", 32'(so4), 0);
        rst = 1'b0;
        tick;
        // basic serve with a stalled ready
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("serve_valid_start", 32'(serve_valid), 1);
        chk("serve_player_start", 32'(serve_player), 0);
        chk("rally_in_serve", 32'(rally_active), 0);
        tick;
        tick;
        chk("serve_valid_held", 32'(serve_valid), 1);
        chk("serve_player_held", 32'(serve_player), 0);
        serve_ready = 1'b1;
        tick;
        serve_ready = 1'b0;
        chk("serve_valid_drop", 32'(serve_valid), 0);
        chk("rally_after_hs", 32'(rally_active), 1);
        // player 1 scores, then an ignored event during PAUSE
        point(2'b10);
        chk("score_p1", 32'(score_out), 32'h0100);
        chk("serve_player_p1", 32'(serve_player), 1);
        chk("rally_off", 32'(rally_active), 0);
        point(2'b01);
        chk("evt_in_pause_score", 32'(score_out), 32'h0100);
        chk("evt_in_pause_err", 32'(evt_error), 0);
        tick;
        tick;
        chk("pause_still", 32'(serve_valid), 0);
        tick;
        chk("pause_end_serve", 32'(serve_valid), 1);
        chk("pause_end_player", 32'(serve_player), 1);
        serve_ready = 1'b1;
        tick;
        chk("rally_again", 32'(rally_active), 1);
        // multi-hot event
        point(2'b11);
        chk("multi_score", 32'(score_out), 32'h0100);
        chk("multi_err", 32'(evt_error), 1);
        chk("multi_rally", 32'(rally_active), 1);
        // player 0 runs to 11
        for (int k = 1; k <= 11; k++) begin
            point(2'b01);
            chk("win_run_score", 32'(score_out), 32'h0100 | k);
            chk("win_run_go", 32'(game_over), (k == 11) ? 1 : 0);
            if (k < 11) wait_rally;
        end
        chk("winner_p0", 32'(winner), 0);
        chk("go_rally_off", 32'(rally_active), 0);
        point(2'b10);
        chk("go_hold_score", 32'(score_out), 32'h010B);
        chk("go_hold", 32'(game_over), 1);
        chk("err_sticky", 32'(evt_error), 1);
        // restart clears the match
        serve_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_score", 32'(score_out), 0);
        chk("restart_go", 32'(game_over), 0);
        chk("restart_err", 32'(evt_error), 0);
        chk("restart_serve", 32'(serve_valid), 1);
        serve_ready = 1'b1;
        tick;
        point(2'b10);
        serve_ready = 1'b0;
        wait_serve;
        chk("pre_rst_score", 32'(score_out), 32'h0100);
        // asynchronous reset in the middle of SERVE
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(serve_valid), 0);
        chk("async_rst_score", 32'(score_out), 0);
        chk("async_rst_player", 32'(serve_player), 0);
        chk("async_rst_rally", 32'(rally_active), 0);
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_idle", 32'(serve_valid), 0);
`ifdef PONG_WIN_BY_TWO_EN
        serve_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_rally;
        for (int k = 0; k < 10; k++) begin
            point(2'b01);
            wait_rally;
            point(2'b10);
            wait_rally;
        end
        chk("w2_tie", 32'(score_out), 32'h0A0A);
        point(2'b01);
        chk("w2_11_10_score", 32'(score_out), 32'h0A0B);
        chk("w2_11_10_go", 32'(game_over), 0);
        wait_rally;
        point(2'b01);
        chk("w2_12_10_score", 32'(score_out), 32'h0A0C);
        chk("w2_12_10_go", 32'(game_over), 1);
        chk("w2_winner", 32'(winner), 0);
`endif
        // four players, two-bit scores, win at 3, zero pause
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        chk("p4_serve", 32'(sv4), 1);
        tick;
        chk("p4_rally", 32'(ra4), 1);
        evt4 = 4'b1000;
        tick;
        evt4 = 4'b0;
        chk("p4_score1", 32'(so4), 32'h40);
        chk("p4_player", 32'(sp4), 3);
        chk("p4_pause", 32'(sv4), 0);
        tick;
        chk("p4_pause_1cyc", 32'(sv4), 1);
        tick;
        evt4 = 4'b1000;
        tick;
        evt4 = 4'b0;
        chk("p4_score2", 32'(so4), 32'h80);
        chk("p4_go_early", 32'(go4), 0);
        tick;
        tick;
        chk("p4_rally3", 32'(ra4), 1);
        evt4 = 4'b1000;
        tick;
        evt4 = 4'b0;
        chk("p4_score3", 32'(so4), 32'hC0);
        chk("p4_go", 32'(go4), 1);
        chk("p4_winner", 32'(w4), 3);
        chk("p4_err", 32'(ee4), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
